// File: rtl/uart_pkg.sv
// Shared UART constants and receive-state encoding, intended for both the RX and TX controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        S_RX_IDLE      = 3'd0,
        S_RX_START_BIT = 3'd1,
        S_RX_DATA_BITS = 3'd2,
        S_RX_STOP_BIT  = 3'd3,
        S_RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int SAMPLE_TICK = 7;
    localparam int DATA_BITS   = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; both flops reset to the idle-high level.
module uart_rx_sync (
    input  logic Clk,
    input  logic Resetn,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_receive_controller.sv
// 8N1 UART receiver on a shared 16x baud_tick; emits one-cycle FIFO write / error strobes.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote of samples at ticks 6, 7 and 8.
module uart_receive_controller
    import uart_pkg::*;
(
    input  logic       Clk,
    input  logic       Resetn,
    input  logic       baud_tick,
    input  logic       UART_RX_O,
    input  logic       Full,
    output logic [7:0] r_data,
    output logic       r_valid,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam logic [3:0] C_LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] C_LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t  r_state;
    logic [3:0] r_tick_count;
    logic [2:0] r_data_count;
    logic [7:0] r_shift;
    logic [1:0] r_settle;
    logic       r_armed;
    logic       w_rx_s;
    logic       w_bit;
    logic       w_decide;
    logic       w_bit_end;

    uart_rx_sync u_rx_sync (
        .Clk     (Clk),
        .Resetn  (Resetn),
        .i_async (UART_RX_O),
        .o_sync  (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] C_DECIDE = 4'(SAMPLE_TICK + 1);

    logic r_samp_early;
    logic r_samp_mid;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_samp_early <= 1'b1;
            r_samp_mid   <= 1'b1;
        end else if (baud_tick) begin
            if (r_tick_count == 4'(SAMPLE_TICK - 1))
                r_samp_early <= w_rx_s;
            if (r_tick_count == 4'(SAMPLE_TICK))
                r_samp_mid <= w_rx_s;
        end
    end

    assign w_bit = maj3(r_samp_early, r_samp_mid, w_rx_s);
`else
    localparam logic [3:0] C_DECIDE = 4'(SAMPLE_TICK);

    assign w_bit = w_rx_s;
`endif

    assign w_decide  = baud_tick && (r_tick_count == C_DECIDE);
    assign w_bit_end = baud_tick && (r_tick_count == C_LAST_TICK);

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state      <= S_RX_IDLE;
            r_tick_count <= 4'd0;
            r_data_count <= 3'd0;
            r_shift      <= 8'd0;
            r_settle     <= 2'b00;
            r_armed      <= 1'b0;
            r_data       <= 8'd0;
            r_valid      <= 1'b0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            r_settle    <= {r_settle[0], 1'b1};
            if (baud_tick)
                r_tick_count <= r_tick_count + 4'd1;

            case (r_state)
                S_RX_IDLE: begin
                    // After reset the line must be seen high (past the synchronizer) before a start is accepted.
                    if (!r_armed) begin
                        r_armed <= r_settle[1] & w_rx_s;
                    end else if (!w_rx_s) begin
                        r_tick_count <= 4'd0;
                        r_state      <= S_RX_START_BIT;
                    end
                end
                S_RX_START_BIT: begin
                    if (w_decide && w_bit) begin
                        r_state <= S_RX_IDLE;
                    end else if (w_bit_end) begin
                        r_data_count <= 3'd0;
                        r_state      <= S_RX_DATA_BITS;
                    end
                end
                S_RX_DATA_BITS: begin
                    if (w_decide)
                        r_shift <= {w_bit, r_shift[7:1]};
                    if (w_bit_end) begin
                        r_data_count <= r_data_count + 3'd1;
                        if (r_data_count == C_LAST_BIT)
                            r_state <= S_RX_STOP_BIT;
                    end
                end
                S_RX_STOP_BIT: begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be caught on time.
                    if (w_decide) begin
                        if (!w_bit) begin
                            frame_err <= 1'b1;
                            r_state   <= S_RX_WAIT_HIGH;
                        end else if (Full) begin
                            overrun_err <= 1'b1;
                            r_state     <= S_RX_IDLE;
                        end else begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= S_RX_IDLE;
                        end
                    end
                end
                S_RX_WAIT_HIGH: begin
                    if (w_rx_s)
                        r_state <= S_RX_IDLE;
                end
                default: r_state <= S_RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receive_controller.sv
// Self-checking bench for uart_receive_controller: directed scenarios plus randomized frames
// compared against a frame-level model (byte, stop level, Full -> expected strobe).
`timescale 1ns/1ps
module tb_uart_receive_controller;

    logic       Clk       = 1'b0;
    logic       Resetn    = 1'b0;
    logic       baud_tick = 1'b0;
    logic       UART_RX_O = 1'b1;
    logic       Full      = 1'b0;
    logic [7:0] r_data;
    logic       r_valid;
    logic       frame_err;
    logic       overrun_err;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_num = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         tick;
    } ev_t;
    ev_t evq[$];

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_OVR   = 3'b100;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 153;
    localparam logic [7:0] SPIKE_EXP = 8'h00;
`else
    localparam int LAT = 152;
    localparam logic [7:0] SPIKE_EXP = 8'h08;
`endif

    uart_receive_controller dut (
        .Clk         (Clk),
        .Resetn      (Resetn),
        .baud_tick   (baud_tick),
        .UART_RX_O   (UART_RX_O),
        .Full        (Full),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 Clk = ~Clk;

    // One baud tick every 4 clocks, updated 2 ns after the edge.
    initial begin : tickgen
        int div;
        div = 0;
        forever begin
            @(posedge Clk);
            #2;
            div = (div + 1) % 4;
            baud_tick = (div == 0);
            if (baud_tick) tick_num++;
        end
    end

    always @(negedge Clk) begin : monitor
        ev_t e;
        if (r_valid || frame_err || overrun_err) begin
            e.kind = {overrun_err, frame_err, r_valid};
            e.data = r_data;
            e.tick = tick_num;
            evq.push_back(e);
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: run still going at time limit, required completion");
        $fatal(1, "time limit reached");
    end

    function automatic logic [2:0] model_kind(input logic stop, input logic full);
        if (!stop) return K_FERR;
        if (full)  return K_OVR;
        return K_VALID;
    endfunction

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            while (baud_tick !== 1'b1) @(posedge Clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        t0 = tick_num;
        UART_RX_O = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            UART_RX_O = b[i];
            wait_ticks(16);
        end
        UART_RX_O = stop;
        wait_ticks(16);
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        UART_RX_O = 1'b1;
        Full = 1'b0;
        #23;
        n_checks++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid: got %b required 0", r_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
        n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun_err: got %b required 0", overrun_err); end
        n_checks++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL reset_r_data: got %h required 00", r_data); end
        #14 Resetn = 1'b1;
        wait_ticks(20);
        n_checks++; if (evq.size() != 0) begin n_fail++; $display("FAIL reset_idle_strobes: got %0d required 0", evq.size()); end
    endtask

    task automatic test_basic_frame;
        int t0;
        ev_t e;
        evq.delete();
        send_frame(8'hA5, 1'b1, t0);
        UART_RX_O = 1'b1;
        wait_ticks(4);
        n_checks++;
        if (evq.size() != 1) begin
            n_fail++; $display("FAIL basic_count: got %0d strobes required 1", evq.size());
        end else begin
            e = evq.pop_front();
            n_checks++; if (e.kind !== K_VALID) begin n_fail++; $display("FAIL basic_kind: got %b required %b", e.kind, K_VALID); end
            n_checks++; if (e.data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h required a5", e.data); end
            n_checks++;
            if ((e.tick - t0) < LAT - 1 || (e.tick - t0) > LAT + 1) begin
                n_fail++; $display("FAIL basic_latency: got %0d ticks required %0d", e.tick - t0, LAT);
            end
        end
        last_good = 8'hA5;
        n_checks++; if (r_data !== 8'hA5) begin n_fail++; $display("FAIL basic_hold: got %h required a5", r_data); end
    endtask

    task automatic test_back_to_back;
        int t0a, t0b;
        ev_t e;
        evq.delete();
        send_frame(8'h00, 1'b1, t0a);
        send_frame(8'hFF, 1'b1, t0b);
        UART_RX_O = 1'b1;
        wait_ticks(4);
        n_checks++;
        if (evq.size() != 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d strobes required 2", evq.size());
        end else begin
            e = evq.pop_front();
            n_checks++; if (e.kind !== K_VALID || e.data !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got kind %b data %h required %b 00", e.kind, e.data, K_VALID); end
            e = evq.pop_front();
            n_checks++; if (e.kind !== K_VALID || e.data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got kind %b data %h required %b ff", e.kind, e.data, K_VALID); end
            n_checks++;
            if ((e.tick - t0b) < LAT - 1 || (e.tick - t0b) > LAT + 1) begin
                n_fail++; $display("FAIL b2b_latency: got %0d ticks required %0d", e.tick - t0b, LAT);
            end
        end
        last_good = 8'hFF;
    endtask

    task automatic test_glitch;
        int t0;
        ev_t e;
        evq.delete();
        wait_ticks(2);
        UART_RX_O = 1'b0;
        wait_ticks(4);
        UART_RX_O = 1'b1;
        wait_ticks(40);
        n_checks++; if (evq.size() != 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d required 0", evq.size()); end
        evq.delete();
        send_frame(8'h5A, 1'b1, t0);
        UART_RX_O = 1'b1;
        wait_ticks(4);
        n_checks++;
        if (evq.size() != 1) begin
            n_fail++; $display("FAIL glitch_next_count: got %0d required 1", evq.size());
        end else begin
            e = evq.pop_front();
            n_checks++; if (e.kind !== K_VALID || e.data !== 8'h5A) begin n_fail++; $display("FAIL glitch_next_frame: got kind %b data %h required %b 5a", e.kind, e.data, K_VALID); end
        end
        last_good = 8'h5A;
    endtask

    task automatic test_frame_error;
        int t0;
        ev_t e;
        evq.delete();
        send_frame(8'h3C, 1'b0, t0);
        wait_ticks(320);
        n_checks++;
        if (evq.size() != 1) begin
            n_fail++; $display("FAIL ferr_count: got %0d strobes required 1", evq.size());
        end else begin
            e = evq.pop_front();
            n_checks++; if (e.kind !== K_FERR) begin n_fail++; $display("FAIL ferr_kind: got %b required %b", e.kind, K_FERR); end
        end
        n_checks++; if (r_data !== last_good) begin n_fail++; $display("FAIL ferr_hold: got %h required %h", r_data, last_good); end
        UART_RX_O = 1'b1;
        wait_ticks(8);
        evq.delete();
        send_frame(8'h55, 1'b1, t0);
        UART_RX_O = 1'b1;
        wait_ticks(4);
        n_checks++;
        if (evq.size() != 1) begin
            n_fail++; $display("FAIL ferr_recover_count: got %0d required 1", evq.size());
        end else begin
            e = evq.pop_front();
            n_checks++; if (e.kind !== K_VALID || e.data !== 8'h55) begin n_fail++; $display("FAIL ferr_recover: got kind %b data %h required %b 55", e.kind, e.data, K_VALID); end
        end
        last_good = 8'h55;
    endtask

    task automatic test_overrun;
        int t0;
        ev_t e;
        evq.delete();
        Full = 1'b1;
        send_frame(8'h81, 1'b1, t0);
        Full = 1'b0;
        UART_RX_O = 1'b1;
        wait_ticks(4);
        n_checks++;
        if (evq.size() != 1) begin
            n_fail++; $display("FAIL ovr_count: got %0d strobes required 1", evq.size());
        end else begin
            e = evq.pop_front();
            n_checks++; if (e.kind !== K_OVR) begin n_fail++; $display("FAIL ovr_kind: got %b required %b", e.kind, K_OVR); end
        end
        n_checks++; if (r_data !== last_good) begin n_fail++; $display("FAIL ovr_hold: got %h required %h", r_data, last_good); end
    endtask

    task automatic test_spike;
        ev_t e;
        evq.delete();
        wait_ticks(2);
        UART_RX_O = 1'b0;
        wait_ticks(16);
        UART_RX_O = 1'b0;
        wait_ticks(48);
        // Line is high only while the receiver's tick counter reads 7 in data bit 3.
        wait_ticks(7);
        UART_RX_O = 1'b1;
        wait_ticks(1);
        UART_RX_O = 1'b0;
        wait_ticks(8);
        wait_ticks(64);
        UART_RX_O = 1'b1;
        wait_ticks(20);
        n_checks++;
        if (evq.size() != 1) begin
            n_fail++; $display("FAIL spike_count: got %0d strobes required 1", evq.size());
        end else begin
            e = evq.pop_front();
            n_checks++; if (e.kind !== K_VALID || e.data !== SPIKE_EXP) begin n_fail++; $display("FAIL spike_data: got kind %b data %h required %b %h", e.kind, e.data, K_VALID, SPIKE_EXP); end
        end
        last_good = SPIKE_EXP;
    endtask

    task automatic test_reset_mid_frame;
        int t0;
        ev_t e;
        evq.delete();
        wait_ticks(2);
        UART_RX_O = 1'b0;
        wait_ticks(16);
        UART_RX_O = 1'b1;
        wait_ticks(40);
        UART_RX_O = 1'b0;
        #3 Resetn = 1'b0;
        #2;
        n_checks++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL midrst_r_data: got %h required 00", r_data); end
        n_checks++; if ({r_valid, frame_err, overrun_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_strobes: got %b required 000", {r_valid, frame_err, overrun_err}); end
        repeat (5) @(posedge Clk);
        #3 Resetn = 1'b1;
        last_good = 8'h00;
        wait_ticks(40);
        n_checks++; if (evq.size() != 0) begin n_fail++; $display("FAIL midrst_low_line: got %0d strobes required 0", evq.size()); end
        UART_RX_O = 1'b1;
        wait_ticks(20);
        n_checks++; if (evq.size() != 0) begin n_fail++; $display("FAIL midrst_no_strobe: got %0d strobes required 0", evq.size()); end
        evq.delete();
        send_frame(8'h96, 1'b1, t0);
        UART_RX_O = 1'b1;
        wait_ticks(4);
        n_checks++;
        if (evq.size() != 1) begin
            n_fail++; $display("FAIL midrst_next_count: got %0d required 1", evq.size());
        end else begin
            e = evq.pop_front();
            n_checks++; if (e.kind !== K_VALID || e.data !== 8'h96) begin n_fail++; $display("FAIL midrst_next_frame: got kind %b data %h required %b 96", e.kind, e.data, K_VALID); end
        end
        last_good = 8'h96;
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       stop;
            logic       full;
            logic [2:0] k;
            int         gap;
            int         t0;
            ev_t        e;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            full = ($urandom_range(0, 3) == 0);
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(2, 4));
            k    = model_kind(stop, full);
            if (k == K_VALID) last_good = b;
            evq.delete();
            Full = full;
            send_frame(b, stop, t0);
            Full = 1'b0;
            n_checks++;
            if (evq.size() != 1) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d strobes required 1", n, evq.size());
            end else begin
                e = evq.pop_front();
                n_checks++; if (e.kind !== k) begin n_fail++; $display("FAIL rand%0d_kind: got %b required %b (byte %h)", n, e.kind, k, b); end
                n_checks++;
                if ((e.tick - t0) < LAT - 1 || (e.tick - t0) > LAT + 1) begin
                    n_fail++; $display("FAIL rand%0d_latency: got %0d ticks required %0d", n, e.tick - t0, LAT);
                end
            end
            n_checks++; if (r_data !== last_good) begin n_fail++; $display("FAIL rand%0d_r_data: got %h required %h", n, r_data, last_good); end
            UART_RX_O = 1'b1;
            if (gap > 0) wait_ticks(gap);
        end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_overrun;
        test_spike;
        test_reset_mid_frame;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
